// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: source ids, FSM states, one-hot helper.
package wb_pkg;
    localparam int N_SRC = 4;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_IMM = 2'd2,
        SRC_MOV = 2'd3
    } wb_src_e;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_e;

    function automatic logic [N_SRC-1:0] onehot(input logic [1:0] idx);
        return (N_SRC)'(1) << idx;
    endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back request/grant bundle between result sources and the register-file write port.
interface wb_arbiter_if #(parameter int ADDR_W = 3);
    logic [3:0]        req;
    logic [ADDR_W-1:0] dest0;
    logic [ADDR_W-1:0] dest1;
    logic [ADDR_W-1:0] dest2;
    logic [ADDR_W-1:0] dest3;
    logic              flush;
    logic [1:0]        select;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        ack;
    logic              busy;

    modport master (
        output req, dest0, dest1, dest2, dest3, flush,
        input  select, wr_en, wr_addr, ack, busy
    );

    modport slave (
        input  req, dest0, dest1, dest2, dest3, flush,
        output select, wr_en, wr_addr, ack, busy
    );
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational priority picker: first set request bit at or after start, wrapping mod 4.
// Zero latency; no backpressure of its own.
module wb_rr_pick
    import wb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [1:0]       start,
    output logic             found,
    output logic [1:0]       winner
);
    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest request is the last to overwrite.
    always_comb begin
        found  = 1'b0;
        winner = start;
        idx    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants one of four sources the register-file write port per cycle.
// Latency 1 cycle req->ack; flush or mask withholds the grant. Build with WB_ROUND_ROBIN_EN for round-robin.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_arbiter_if.slave bus
);
`ifdef WB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    wb_state_e         state, state_nxt;
    logic [1:0]        last;
    logic [1:0]        start;
    logic [1:0]        winner;
    logic              found;
    logic              grant;
    logic [N_SRC-1:0]  avail;
    logic [ADDR_W-1:0] dest_win;

    // The source being written this cycle is masked so it cannot win twice in a row.
    assign avail    = bus.req & ~bus.ack;
    assign bus.busy = |avail;

    // Fixed priority forces the search to begin at source 0; last is kept regardless.
    assign start = (last + 2'd1) & {2{RR_EN}};

    wb_rr_pick u_pick (
        .req    (avail),
        .start  (start),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        case (winner)
            2'd0:    dest_win = bus.dest0;
            2'd1:    dest_win = bus.dest1;
            2'd2:    dest_win = bus.dest2;
            default: dest_win = bus.dest3;
        endcase
    end

    always_comb begin
        state_nxt = WB_IDLE;
        grant     = found && !bus.flush;
        if (grant) state_nxt = WB_WRITE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WB_IDLE;
        else        state <= state_nxt;
    end

    assign bus.wr_en = (state == WB_WRITE);

    // select/wr_addr hold on idle cycles to keep the write-data mux quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.select  <= 2'd0;
            bus.wr_addr <= '0;
            bus.ack     <= '0;
            last        <= 2'd3;
        end else if (grant) begin
            bus.select  <= winner;
            bus.wr_addr <= dest_win;
            bus.ack     <= onehot(winner);
            last        <= winner;
        end else begin
            bus.ack     <= '0;
        end
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that shares the single register-file write port between four result sources: ALU, data memory load, immediate, and register move. It drives the 2-bit select of the 4:1 write-data mux (`choice0`..`choice3`), plus the register-file write enable and destination address. It returns a per-source acknowledge. It sits between the execute/memory stages and the register file, and is the only block allowed to assert a register-file write.

## Interface
- `ADDR_W`, default 3: register-address width.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: per-source write request; bit i corresponds to mux `choice`i.
- `dest0`..`dest3`  in  ADDR_W: destination register of source i; valid while `req[i]` is high.
- `flush`  in  1: synchronous cancel; no grant is issued in a cycle where `flush` is sampled high.
- `select`  out  2: write-data mux select; drives the mux `select` port.
- `wr_en`  out  1: register-file write enable.
- `wr_addr`  out  ADDR_W: register-file write address.
- `ack`  out  4: one-hot acknowledge; high in the cycle the write happens.
- `busy`  out  1: combinational; high when any unmasked `req` is pending this cycle.

## Operation
- FSM has two states:
  - IDLE: `wr_en`=0.
  - WRITE: `wr_en`=1.
- FSM transitions:
  - From either state, go to WRITE when the arbitration winner exists and `flush`=0.
  - Otherwise go to IDLE.
- Arbitration is combinational over `req & ~mask`. `mask` is the `ack` of the current cycle, so the source being written this cycle cannot win again this cycle.
- On a win, registered on the next edge:
  - `select` = winner index
  - `wr_addr` = `dest`[winner]
  - `ack` = onehot(winner)
  - `wr_en` = 1
- Priority pointer `last` is updated to the winner only on a grant.
- Request handshake:
  - A source holds `req`, `dest` and its `choice` data stable from assertion through its `ack` cycle inclusive.
  - `req` still high in the cycle after `ack` is a new transaction.
- Outputs with no grant:
  - `wr_en`=0 and `ack`=0.
  - `select` and `wr_addr` hold their previous values, to avoid needless mux toggling.
- `flush` wins over any request; the pointer is not updated.
- Reset values: `select`=0, `wr_en`=0, `wr_addr`=0, `ack`=0, `last`=3, state IDLE.
- Reset is asynchronous. Assertion mid-write drops `wr_en` and `ack` immediately, and no partial write is owed to the source.

## Timing
- Latency: `req` sampled at edge N produces `wr_en`/`ack` during cycle N+1.
- Register-file writes at edge N+2, using mux data valid during N+1.
- Throughput: one write per cycle when different sources alternate.
- A single source requesting continuously gets every other cycle, because of the mask.
- `busy` is the only combinational output; all others are registered.

## Configuration
- `WB_ROUND_ROBIN_EN` defined:
  - Round-robin priority.
  - Search starts at (`last`+1) mod 4.
- `WB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, source 0 highest, then 1, 2, 3.
  - `last` is still maintained but ignored.
- The `mask` rule applies in both modes.

## Structure
- Package `wb_pkg` holds:
  - `N_SRC`=4
  - enum `wb_src_e` {`SRC_ALU`=0, `SRC_MEM`=1, `SRC_IMM`=2, `SRC_MOV`=3}
  - enum `wb_state_e` {`WB_IDLE`, `WB_WRITE`}
- Sub-module `wb_rr_pick`: combinational.
  - Inputs: 4-bit request vector and 2-bit start index.
  - Outputs: `found` and 2-bit `winner`.
  - Fixed mode ties start index to 0.

## Test plan
- Reset:
  - Hold `rst_n`=0 with `req`=1111.
  - Expect `wr_en`=0, `ack`=0, `select`=00, `wr_addr`=0 throughout.
- Single request:
  - `req`=0010, `dest1`=5 at edge N, dropped after `ack`.
  - Cycle N+1: `select`=01, `wr_addr`=5, `wr_en`=1, `ack`=0010.
  - Cycle N+2: `wr_en`=0.
- Round-robin (macro defined):
  - `req`=1111 held, dests 1,2,3,4.
  - Expect back-to-back `select` 00,01,10,11,00 with `wr_addr` 1,2,3,4,1.
  - Expect `wr_en` continuously 1.
- Fixed priority (macro undefined):
  - `req`=1010 held.
  - Expect `ack` sequence 0010, 1000, 0010, 1000 with no idle cycles.
- Lone repeater:
  - `req`=0001 held 6 cycles.
  - Expect `wr_en` 1,0,1,0,1,0.
- Flush and reset:
  - `flush`=1 with `req`=0100: next cycle `wr_en`=0 and `ack`=0.
  - `rst_n` dropped mid-WRITE: `wr_en` falls without waiting for a clock edge.
